// File: rtl/uart_tx_stream_pkg.sv
// Shared UART definitions: default bit timing and transmit FSM state encoding.
// The receive path imports the same package so both sides agree on encoding and baud defaults.
package uart_tx_stream_pkg;

  localparam int unsigned UartClksPerBitDefault = 434;  // 115200 baud at 50 MHz
  localparam int unsigned UartFifoAwDefault     = 8;
  localparam int unsigned UartDataW             = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_stream_if.sv
// Byte-write port and transmitter status bundle for uart_tx_stream.
// The master side writes bytes and observes status; the slave side is the transmitter.
interface uart_tx_stream_if #(
  parameter int unsigned FIFO_AW = uart_tx_stream_pkg::UartFifoAwDefault
);

  logic               wr_en;
  logic [7:0]         wr_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_count;
  logic               overflow;
  logic               uart_tx;
  logic               tx_busy;
  logic               tx_done;

  modport master (
    output wr_en,
    output wr_data,
    input  fifo_full,
    input  fifo_empty,
    input  fifo_count,
    input  overflow,
    input  uart_tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output fifo_full,
    output fifo_empty,
    output fifo_count,
    output overflow,
    output uart_tx,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered count/full/empty and a one-cycle overflow pulse.
// A write while full is still accepted when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AW    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [DataW-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic             overflow_o
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] CountFull = (AW+1)'(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  always_comb begin
    pop        = rd_en_i & ~empty_q;
    push       = wr_en_i & (~full_q | pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
    full_d     = (count_d == CountFull);
    empty_d    = (count_d == '0);
    overflow_d = wr_en_i & full_q & ~pop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-buffered 8N1 UART transmitter: bytes written through the bus are sent LSB first,
// back-to-back frames with no idle gap while the FIFO has data.
module uart_tx_stream
  import uart_tx_stream_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartClksPerBitDefault,
  parameter int unsigned FIFO_AW      = UartFifoAwDefault
) (
  input logic               CLK,
  input logic               RST_N,
  uart_tx_stream_if.slave   bus
);

  localparam int unsigned        BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0]   BaudLast = BaudW'(CLKS_PER_BIT - 1);

  uart_state_e          state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 pop;
  logic                 baud_end;
  logic                 fifo_empty;
  logic [7:0]           fifo_rd_data;

  uart_tx_fifo #(
    .DataW (UartDataW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .wr_en_i    (bus.wr_en),
    .wr_data_i  (bus.wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .full_o     (bus.fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (bus.fifo_count),
    .overflow_o (bus.overflow)
  );

  assign baud_end = (baud_q == BaudLast);

  // tx_d is computed for the state being entered so the line is a clean flop output.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BaudW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
          tx_d      = shift_q[0];
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.fifo_empty = fifo_empty;
  assign bus.uart_tx    = tx_q;
  assign bus.tx_busy    = (state_q != StIdle);
  assign bus.tx_done    = (state_q == StStop) && baud_end;

endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving CLK cycles per UART bit (115200 baud at 50 MHz), legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_AW, default 8, giving FIFO depth 2^FIFO_AW = 256 bytes.
REQ-003 The block SHALL have port CLK  input  1  system clock; all logic is rising-edge.
REQ-004 The block SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port wr_en  input  1  byte-write strobe, sampled each CLK.
REQ-006 The block SHALL have port wr_data  input  8  byte to enqueue when wr_en is high.
REQ-007 The block SHALL have port fifo_full  output  1  FIFO holds 2^FIFO_AW bytes.
REQ-008 The block SHALL have port fifo_empty  output  1  FIFO holds 0 bytes.
REQ-009 The block SHALL have port fifo_count  output  FIFO_AW+1  bytes currently queued.
REQ-010 The block SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 The block SHALL have port uart_tx  output  1  serial line, idle high.
REQ-012 The block SHALL have port tx_busy  output  1  high while any frame bit is being driven.
REQ-013 The block SHALL have port tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-014 A write SHALL be accepted when wr_en=1 and fifo_full=0 in the same cycle, whether or not a pop occurs in that cycle.
REQ-015 A write with fifo_full=1 SHALL be dropped, leave FIFO contents unchanged, and pulse overflow in the next cycle.
REQ-016 fifo_count SHALL update one cycle after a write or a pop: +1 for a write alone, -1 for a pop alone, unchanged for both; fifo_full and fifo_empty SHALL be registered and derived from fifo_count.
REQ-017 Byte order SHALL be strict FIFO; pointers SHALL wrap modulo 2^FIFO_AW with no lost or duplicated byte at wrap.
REQ-018 The FSM SHALL have states IDLE, START, DATA, and STOP.
REQ-019 In IDLE with fifo_empty=0, the FSM SHALL pop one byte into an 8-bit shift register and enter START in the next cycle.
REQ-020 Latency SHALL be such that a write at cycle N into an empty FIFO, with the FSM in IDLE, drives uart_tx low from cycle N+2.
REQ-021 START SHALL drive uart_tx=0 for CLKS_PER_BIT cycles and then enter DATA.
REQ-022 DATA SHALL drive bits 0..7, LSB first, for CLKS_PER_BIT cycles each, tracked by a 3-bit bit index, and then enter STOP.
REQ-023 STOP SHALL drive uart_tx=1 for CLKS_PER_BIT cycles; tx_done SHALL pulse in the last STOP cycle.
REQ-024 At the end of STOP, if fifo_empty=0, the FSM SHALL pop and go directly to START so the next start bit immediately follows the stop bit with no idle gap; otherwise it SHALL return to IDLE.
REQ-025 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, reset to 0 on every state entry, and compare against CLKS_PER_BIT-1.
REQ-026 tx_busy SHALL be 1 in START, DATA, and STOP, and 0 in IDLE.
REQ-027 uart_tx SHALL be registered and glitch-free.

Reset
REQ-028 Asserting RST_N low at any time, including mid-frame, SHALL asynchronously set state=IDLE, uart_tx=1, tx_busy=0, tx_done=0, overflow=0, fifo_count=0, fifo_empty=1, fifo_full=0, and pointers=0.
REQ-029 A frame interrupted by reset SHALL be abandoned and never resumed; FIFO storage RAM need not be cleared.

Structure
REQ-030 The FSM state encoding and the default CLKS_PER_BIT SHALL reside in the shared UART package or header used by the UART receive path.
REQ-031 FIFO storage and pointer logic SHALL be one sub-module, uart_tx_fifo, parameterized by data width 8 and FIFO_AW; the FSM, shift register, and baud counter SHALL reside in uart_tx_stream.

Verification (CLKS_PER_BIT=4, FIFO_AW=2)
REQ-032 Write 0xA5 at cycle 10 -> uart_tx low over cycles 12-15, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, high over cycles 48-51, tx_done pulse at cycle 51.
REQ-033 Write 0x01, 0x02, 0x03 back-to-back -> three frames with the start bit immediately after each stop bit, three tx_done pulses 40 cycles apart, and fifo_empty=1 after the third pop.
REQ-034 Write 6 bytes in consecutive cycles while one frame is active -> 4 bytes queued, fifo_full=1, overflow pulses for the dropped writes, and exactly the first 5 bytes transmitted in order.
REQ-035 Simultaneous write and pop with fifo_full=1 -> write accepted, fifo_count stays 4, no overflow pulse.
REQ-036 Assert RST_N low during DATA bit 3 -> uart_tx=1 and fifo_count=0 immediately; after release, a write of 0x5A produces one clean frame.
REQ-037 Run 20 bytes through the depth-4 FIFO -> received byte sequence equals the written sequence across pointer wrap.
